// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display data/command and pin bundle for seg7_scan_driver
// Purpose: groups the value/mask/load/mode controls and the seg/dig_en/frame_done pins.
// Ports (signals):
//   value       4*NUM_DIGITS  nibble k -> digit k
//   blank_mask  NUM_DIGITS    1 = digit k dark
//   load        1             capture value/blank_mask into shadow
//   mode        2             00 hex, 01 spinner, 10 hex+blink, 11 off
//   seg         7             {g,f,e,d,c,b,a}
//   dig_en      NUM_DIGITS    one-hot digit enable
//   frame_done  1             pulse at start of each new frame
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    load;
  logic [1:0]              mode;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_done;

  modport master (
    output value, blank_mask, load, mode,
    input  seg, dig_en, frame_done
  );

  modport slave (
    input  value, blank_mask, load, mode,
    output seg, dig_en, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment scan driver
// Purpose: scans NUM_DIGITS digits on a shared segment bus, hex or spinner glyphs,
//          per-digit blanking, blink mode, value commit on frame boundaries.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    slave side of seg7_scan_driver_if (value/blank_mask/load/mode in,
//          seg/dig_en/frame_done out, all outputs registered)
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_driver_if.slave   bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [FW-1:0]           r_frame_cnt;
  logic                    r_blink;
  logic                    r_wrapped;
  logic [4*NUM_DIGITS-1:0] r_sh_val;
  logic [NUM_DIGITS-1:0]   r_sh_mask;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_mask;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_fd;

  logic                    w_step;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_mask_bit;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_glyph;
  logic                    w_blank;
  logic [6:0]              w_lit;

  assign w_step = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_wrap = w_step && (r_idx == IW'(NUM_DIGITS - 1));

  // Select the active digit's nibble/mask bit and build its one-hot enable.
  always_comb begin
    w_nib      = 4'h0;
    w_mask_bit = 1'b0;
    w_onehot   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib       = r_disp_val[k*4 +: 4];
        w_mask_bit  = r_disp_mask[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // Glyph decode (1 = lit). Spinner glyphs only exist for nibbles 0..3.
  always_comb begin
    w_glyph = 7'h00;
    if (bus.mode == 2'b01) begin
      if (w_nib[3:2] == 2'b00) begin
        case (w_nib[1:0])
          2'd0:    w_glyph = 7'h07;
          2'd1:    w_glyph = 7'h70;
          2'd2:    w_glyph = 7'h1C;
          default: w_glyph = 7'h63;
        endcase
      end
    end else begin
      case (w_nib)
        4'h0: w_glyph = 7'h3F;  4'h1: w_glyph = 7'h06;
        4'h2: w_glyph = 7'h5B;  4'h3: w_glyph = 7'h4F;
        4'h4: w_glyph = 7'h66;  4'h5: w_glyph = 7'h6D;
        4'h6: w_glyph = 7'h7D;  4'h7: w_glyph = 7'h07;
        4'h8: w_glyph = 7'h7F;  4'h9: w_glyph = 7'h6F;
        4'hA: w_glyph = 7'h77;  4'hB: w_glyph = 7'h7C;
        4'hC: w_glyph = 7'h39;  4'hD: w_glyph = 7'h5E;
        4'hE: w_glyph = 7'h79;  default: w_glyph = 7'h71;
      endcase
    end
  end

  assign w_blank = w_mask_bit || (bus.mode == 2'b11) || ((bus.mode == 2'b10) && r_blink);
  assign w_lit   = w_blank ? 7'h00 : w_glyph;

  // Scan counters, blink timing and shadow/display registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
      r_wrapped   <= 1'b0;
      r_sh_val    <= '0;
      r_sh_mask   <= '0;
      r_disp_val  <= '0;
      r_disp_mask <= '0;
    end else begin
      r_presc <= w_step ? '0 : r_presc + PW'(1);
      if (w_step) r_idx <= w_wrap ? '0 : r_idx + IW'(1);
      if (bus.load) begin
        r_sh_val  <= bus.value;
        r_sh_mask <= bus.blank_mask;
      end
      if (w_wrap) begin
        r_wrapped <= 1'b1;
        if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
        // A load on the wrap cycle bypasses the shadow so it lands in this new frame.
        r_disp_val  <= bus.load ? bus.value      : r_sh_val;
        r_disp_mask <= bus.load ? bus.blank_mask : r_sh_mask;
      end
    end
  end

  // Registered pins. frame_done marks the first cycle digit 0 of a later frame is shown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_OFF;
      r_dig <= DIG_OFF;
      r_fd  <= 1'b0;
    end else begin
      r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_lit : w_lit;
      r_dig <= (DIG_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
      r_fd  <= r_wrapped && (r_presc == '0) && (r_idx == '0);
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dig_en     = r_dig;
  assign bus.frame_done = r_fd;
endmodule
